// File: rtl/axi_top.sv
// Register-mapped top of the regex accelerator: one shared 32-bit program/string RAM,
// host command decode (write, read, start, read elapsed clock) and the regex_engine core.

package axi_package;
  localparam int REG_WIDTH = 32;

  localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
  localparam logic [REG_WIDTH-1:0] CMD_READ               = 32'd2;
  localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd3;
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_ACCEPTED = 2'd2,
    ST_REJECTED = 2'd3
  } status_e;

  // Instruction = {opcode, char}. Any opcode other than these ends the pattern with accept.
  localparam logic [7:0] OP_CHAR = 8'h00;
  localparam logic [7:0] OP_ANY  = 8'h02;
endpackage

// Unanchored pattern search: tries each start position in turn, matching the
// instruction sequence from PC=0 against consecutive characters.
module regex_engine
  import axi_package::*;
#(
  parameter int BB_N          = 1,
  parameter int CC_ID_BITS    = 3,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [REG_WIDTH-1:0]     start_ptr,
  input  logic [REG_WIDTH-1:0]     end_ptr,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  input  logic [REG_WIDTH-1:0]     mem_rdata,
  output logic                     done,
  output logic                     accept
);
  typedef enum logic [1:0] {E_IDLE, E_INS_REQ, E_INS_USE, E_CHR_USE} eng_state_e;

  // Each basic block holds one character window; a program that fills every slot accepts.
  localparam int PC_LIMIT = BB_N << CC_ID_BITS;
  localparam int PC_W     = $clog2(PC_LIMIT + 1);

  eng_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [REG_WIDTH-1:0] base_q, base_d, cur_q, cur_d, end_q, end_d;
  logic [15:0]         instr_q, instr_d;

  logic [15:0] fetched;
  logic [7:0]  fetched_ch;
  logic        fetched_is_match;
  logic        chr_hit;

  assign fetched          = pc_q[0] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign fetched_ch       = mem_rdata[{cur_q[1:0], 3'b000} +: 8];
  assign fetched_is_match = (fetched[15:8] == OP_CHAR) || (fetched[15:8] == OP_ANY);
  assign chr_hit          = (instr_q[15:8] == OP_ANY) || (instr_q[7:0] == fetched_ch);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    base_d   = base_q;
    cur_d    = cur_q;
    end_d    = end_q;
    instr_d  = instr_q;
    mem_addr = MEM_ADDR_BITS'(pc_q >> 1);
    done     = 1'b0;
    accept   = 1'b0;

    unique case (state_q)
      E_IDLE: ;
      E_INS_REQ: state_d = E_INS_USE;
      E_INS_USE: begin
        instr_d = fetched;
        if (pc_q == PC_W'(PC_LIMIT) || !fetched_is_match) begin
          done    = 1'b1;
          accept  = 1'b1;
          state_d = E_IDLE;
        end else if (cur_q > end_q) begin
          // Out of characters here means every later start position is shorter still.
          done    = 1'b1;
          state_d = E_IDLE;
        end else begin
          mem_addr = cur_q[MEM_ADDR_BITS+1:2];
          state_d  = E_CHR_USE;
        end
      end
      E_CHR_USE: begin
        state_d = E_INS_REQ;
        if (chr_hit) begin
          pc_d  = pc_q + PC_W'(1);
          cur_d = cur_q + 1'b1;
        end else begin
          pc_d   = '0;
          base_d = base_q + 1'b1;
          cur_d  = base_q + 1'b1;
        end
      end
      default: state_d = E_IDLE;
    endcase

    if (start) begin
      state_d = E_INS_REQ;
      pc_d    = '0;
      base_d  = start_ptr;
      cur_d   = start_ptr;
      end_d   = end_ptr;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= E_IDLE;
      pc_q    <= '0;
      base_q  <= '0;
      cur_q   <= '0;
      end_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      instr_q <= instr_d;
    end
  end
endmodule

module axi_top
  import axi_package::*;
#(
  parameter int BB_N          = 1,
  parameter int CC_ID_BITS    = 3,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in_register,
  input  logic [31:0] address_register,
  input  logic [31:0] start_cc_pointer_register,
  input  logic [31:0] end_cc_pointer_register,
  input  logic [31:0] cmd_register,
  output logic [31:0] status_register,
  output logic [31:0] data_o_register
);
  localparam int MEM_WORDS = 1 << MEM_ADDR_BITS;

  status_e              status_q, status_d;
  logic [REG_WIDTH-1:0] counter_q, counter_d;
  logic [REG_WIDTH-1:0] data_o_q, data_o_d;

  logic [REG_WIDTH-1:0]     mem_q [MEM_WORDS];
  logic [REG_WIDTH-1:0]     rd_data_q;
  logic [MEM_ADDR_BITS-1:0] host_addr;
  logic [MEM_ADDR_BITS-1:0] core_addr;
  logic [MEM_ADDR_BITS-1:0] rd_addr;

  logic running;
  logic host_write;
  logic start_fire;
  logic core_done;
  logic core_accept;
  logic unused_addr_bits;

  assign host_addr        = address_register[MEM_ADDR_BITS-1:0];
  assign unused_addr_bits = ^address_register[REG_WIDTH-1:MEM_ADDR_BITS];
  assign running          = (status_q == ST_RUNNING);
  assign host_write       = (cmd_register == CMD_WRITE) && !running;
  assign start_fire       = (cmd_register == CMD_START) && !running;
  assign rd_addr          = running ? core_addr : host_addr;

  regex_engine #(
    .BB_N         (BB_N),
    .CC_ID_BITS   (CC_ID_BITS),
    .MEM_ADDR_BITS(MEM_ADDR_BITS)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (start_fire),
    .start_ptr(start_cc_pointer_register),
    .end_ptr  (end_cc_pointer_register),
    .mem_addr (core_addr),
    .mem_rdata(rd_data_q),
    .done     (core_done),
    .accept   (core_accept)
  );

  // NOTE: the RAM and its read register have no reset; contents survive rst like a real SRAM.
  always_ff @(posedge clk) begin
    if (host_write) mem_q[host_addr] <= data_in_register;
    rd_data_q <= mem_q[rd_addr];
  end

  always_comb begin
    status_d  = status_q;
    counter_d = counter_q;
    data_o_d  = data_o_q;

    if (running) begin
      counter_d = counter_q + 1'b1;
      if (core_done) status_d = core_accept ? ST_ACCEPTED : ST_REJECTED;
    end
    if (start_fire) begin
      status_d  = ST_RUNNING;
      counter_d = '0;
    end

    // READ returns the RAM output register, giving two cycles from address to data_o.
    case (cmd_register)
      CMD_NOP:                ;
      CMD_READ:               if (!running) data_o_d = rd_data_q;
      CMD_READ_ELAPSED_CLOCK: data_o_d = counter_q;
      default:                ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q  <= ST_IDLE;
      counter_q <= '0;
      data_o_q  <= '0;
    end else begin
      status_q  <= status_d;
      counter_q <= counter_d;
      data_o_q  <= data_o_d;
    end
  end

  assign status_register = {{(REG_WIDTH-2){1'b0}}, status_q};
  assign data_o_register = data_o_q;
endmodule

// File: tb/tb_axi_top.sv
// Bench for axi_top: directed scenarios plus randomized programs/strings, checked against a
// transaction-level model of the command semantics and a plain substring-search reference.
module tb_axi_top;
  localparam int MEM_WORDS = 1024;
  localparam int PC_LIMIT  = 8;

  localparam logic [31:0] C_NOP = 0, C_WRITE = 1, C_READ = 2, C_START = 3, C_ELAPSED = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_ACC = 2, S_REJ = 3;
  localparam logic [15:0] I_ACCEPT = 16'h0100, I_ANY = 16'h0200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0, addr = '0, sptr = '0, eptr = '0, cmd = '0;
  logic [31:0] status, data_o;

  axi_top #(.BB_N(1), .CC_ID_BITS(3), .MEM_ADDR_BITS(10)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .data_in_register         (data_in),
    .address_register         (addr),
    .start_cc_pointer_register(sptr),
    .end_cc_pointer_register  (eptr),
    .cmd_register             (cmd),
    .status_register          (status),
    .data_o_register          (data_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem   [MEM_WORDS];
  bit          m_known [MEM_WORDS];
  int          m_status = S_IDLE;
  int          m_result = S_IDLE;
  bit          m_first  = 1'b0;
  logic [31:0] m_do     = '0;
  bit          m_do_valid   = 1'b1;
  bit          prev_read_ok = 1'b0;
  logic [9:0]  prev_addr    = '0;
  int unsigned run_count    = 0;

  function automatic logic [7:0] char_at(input longint b);
    logic [31:0] w;
    w = m_mem[int'(b >> 2)];
    return w[int'(b % 4) * 8 +: 8];
  endfunction

  // Accept iff some start position in [s, e] begins a full match of the pattern.
  function automatic int model_result(input logic [31:0] s, input logic [31:0] e);
    logic [7:0]  pat [$];
    bit          any [$];
    logic [31:0] w;
    logic [15:0] ins;
    int          n;
    bit          ok;
    for (int k = 0; k < PC_LIMIT; k++) begin
      w   = m_mem[k / 2];
      ins = (k % 2 == 1) ? w[31:16] : w[15:0];
      if (ins[15:8] == 8'h00)      begin pat.push_back(ins[7:0]); any.push_back(1'b0); end
      else if (ins[15:8] == 8'h02) begin pat.push_back(8'h00);    any.push_back(1'b1); end
      else break;
    end
    n = pat.size();
    if (n == 0) return S_ACC;
    if (e < s) return S_REJ;
    for (longint p = longint'(s); p + n - 1 <= longint'(e); p++) begin
      ok = 1'b1;
      for (int j = 0; j < n; j++)
        if (!any[j] && char_at(p + j) != pat[j]) ok = 1'b0;
      if (ok) return S_ACC;
    end
    return S_REJ;
  endfunction

  // Compare process: outputs seen mid-cycle reflect the previous edge; then the
  // current cycle's command advances the model to what the next edge must produce.
  always @(negedge clk) begin
    bit running;
    if (!rst) begin
      check("reset_status", status, 32'(S_IDLE));
      check("reset_data_o", data_o, 32'h0);
      m_status     = S_IDLE;
      m_first      = 1'b0;
      m_do         = '0;
      m_do_valid   = 1'b1;
      prev_read_ok = 1'b0;
      run_count    = 0;
    end else begin
      if (m_status == S_RUN) begin
        if (m_first) begin
          check("running_after_start", status, 32'(S_RUN));
          m_first = 1'b0;
          if (status == 32'(S_RUN)) run_count++;
        end else if (status == 32'(S_RUN)) begin
          run_count++;
        end else begin
          check("run_result", status, 32'(m_result));
          m_status = m_result;
        end
      end else begin
        check("status", status, 32'(m_status));
      end
      if (m_do_valid) check("data_o", data_o, m_do);

      running = (m_status == S_RUN);
      case (cmd)
        C_WRITE: if (!running) begin
          m_mem[addr[9:0]]   = data_in;
          m_known[addr[9:0]] = 1'b1;
        end
        C_READ: if (!running) begin
          m_do       = m_mem[prev_addr];
          m_do_valid = prev_read_ok && m_known[prev_addr];
        end
        C_START: if (!running) begin
          m_status  = S_RUN;
          m_first   = 1'b1;
          run_count = 0;
          m_result  = model_result(sptr, eptr);
        end
        C_ELAPSED: begin
          m_do       = 32'(run_count);
          m_do_valid = !running;
        end
        default: ;
      endcase
      prev_read_ok = (cmd == C_READ) && !running;
      prev_addr    = addr[9:0];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    cmd = C_WRITE; addr = 32'(a); data_in = d;
    cyc(1);
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    cmd = C_READ; addr = 32'(a);
    cyc(2);
    d = data_o;
  endtask

  task automatic start_run(input logic [31:0] s, input logic [31:0] e);
    cmd = C_START; sptr = s; eptr = e;
    cyc(1);
    cmd = C_NOP;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (status == 32'(S_RUN) && t < 500) begin
      cyc(1);
      t++;
    end
    check(name, status, 32'(m_result));
  endtask

  task automatic read_elapsed(input string name);
    cmd = C_ELAPSED;
    cyc(1);
    cmd = C_NOP;
    check(name, data_o, 32'(run_count));
    check({name, "_nonzero"}, 32'(data_o != 0), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [15:0] h [8];
    logic [31:0] s, e;
    int n, len;

    // 1. reset, then idle
    #2 rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(30);
    check("idle_status", status, 32'(S_IDLE));
    check("idle_data_o", data_o, 32'h0);

    // 2. single write / read
    wr(10'd5, 32'hDEADBEEF);
    rd(10'd5, d);
    check("rd_word5", d, 32'hDEADBEEF);

    // 3. program "abc" at byte 0, string "xabcx" at byte 8, WRITE held throughout
    wr(10'd3, 32'hFFFF_FFFF);
    wr(10'd0, 32'h0062_0061);
    wr(10'd1, 32'h0100_0063);
    wr(10'd2, 32'h6362_6178);
    wr(10'd3, 32'h0000_0078);
    for (int i = 0; i < 4; i++) begin
      cmd = C_READ; addr = 32'(i);
      cyc(1);
    end
    rd(10'd0, d); check("prog_h0", 32'(d[15:0]), 32'h0061); check("prog_h1", 32'(d[31:16]), 32'h0062);
    rd(10'd1, d); check("prog_h2", 32'(d[15:0]), 32'h0063); check("prog_h3", 32'(d[31:16]), 32'h0100);
    rd(10'd2, d); check("str_w2", d, 32'h6362_6178);
    rd(10'd3, d); check("str_w3", d, 32'h0000_0078);
    check("model_xabcx", 32'(model_result(32'd8, 32'd12)), 32'(S_ACC));
    check("model_empty", 32'(model_result(32'd9, 32'd8)), 32'(S_REJ));

    // 4. accepted run
    start_run(32'd8, 32'd12);
    check("run4_running", status, 32'(S_RUN));
    wait_done("run4_done");
    check("run4_accepted", status, 32'(S_ACC));
    read_elapsed("run4_elapsed");

    // 5. rejected run, with START/WRITE/READ issued while running
    wr(10'd4, 32'h7862_6178);
    check("model_xabx", 32'(model_result(32'd16, 32'd19)), 32'(S_REJ));
    start_run(32'd16, 32'd19);
    cyc(2);
    cmd = C_START; sptr = 32'd8; eptr = 32'd12; cyc(1);
    cmd = C_WRITE; addr = 32'd5; data_in = 32'h1234_5678; cyc(1);
    cmd = C_READ; cyc(1);
    cmd = C_NOP;
    check("run5_still_running", status, 32'(S_RUN));
    wait_done("run5_done");
    check("run5_rejected", status, 32'(S_REJ));
    read_elapsed("run5_elapsed");

    // 6. write while running was dropped; then reset mid-run
    rd(10'd5, d);
    check("run5_write_ignored", d, 32'hDEADBEEF);
    start_run(32'd8, 32'd12);
    cyc(3);
    rst = 1'b0;
    #1 check("midrun_reset_status", status, 32'(S_IDLE));
    cyc(1);
    rst = 1'b1;
    cyc(2);
    check("after_reset_status", status, 32'(S_IDLE));

    // empty string with a non-empty pattern
    start_run(32'd9, 32'd8);
    wait_done("empty_done");
    check("empty_rejected", status, 32'(S_REJ));

    // randomized programs and strings
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 5);
      for (int k = 0; k < 8; k++)
        h[k] = (k >= n) ? I_ACCEPT :
               ($urandom_range(0, 5) == 0) ? I_ANY : {8'h00, 8'(8'h61 + $urandom_range(0, 2))};
      for (int k = 0; k < 4; k++) begin
        wr(10'(k), {h[2*k+1], h[2*k]});
        if ($urandom_range(0, 3) == 0) begin
          cmd = 32'($urandom_range(5, 7)); cyc(1);
        end
      end
      for (int k = 8; k < 16; k++)
        wr(10'(k), {8'(8'h61 + $urandom_range(0, 2)), 8'(8'h61 + $urandom_range(0, 2)),
                    8'(8'h61 + $urandom_range(0, 2)), 8'(8'h61 + $urandom_range(0, 2))});
      for (int k = 0; k < 6; k++) begin
        cmd = C_READ; addr = 32'($urandom_range(0, 15));
        cyc(1);
      end
      s   = 32'(32 + $urandom_range(0, 8));
      len = $urandom_range(0, 12);
      e   = ($urandom_range(0, 7) == 0) ? s - 32'd2 : s + 32'(len) - 32'd1;
      start_run(s, e);
      if ($urandom_range(0, 1) == 1) begin
        cyc(1);
        cmd     = 32'($urandom_range(1, 3));
        addr    = 32'($urandom_range(8, 15));
        data_in = 32'h6161_6161;
        sptr    = 32'(32 + $urandom_range(0, 8));
        eptr    = sptr + 32'($urandom_range(0, 10));
        cyc(1);
        cmd = C_NOP;
      end
      wait_done("rand_done");
      cmd = C_ELAPSED;
      cyc(1);
      cmd = C_NOP;
      check("rand_elapsed", data_o, 32'(run_count));
    end

    cyc(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
